// File: rtl/alu_rs_pkg.sv
// Shared ALU definitions: opcode width, opcode encodings and ROB tag width.
package alu_rs_pkg;

  localparam int unsigned Opcode_Width = 4;
  localparam int unsigned TagWidth     = 3;

  typedef enum logic [Opcode_Width-1:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpAnd = 4'd2,
    OpOr  = 4'd3,
    OpXor = 4'd4,
    OpSll = 4'd5,
    OpSrl = 4'd6,
    OpSlt = 4'd7
  } alu_op_e;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: operand storage, CDB capture and dispatch bypass.
module rs_entry
  import alu_rs_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    alloc,
  input  logic                    issue,
  input  logic [Opcode_Width-1:0] disp_op,
  input  logic                    disp_qa_valid,
  input  logic                    disp_qb_valid,
  input  logic [DATA_W-1:0]       disp_va,
  input  logic [DATA_W-1:0]       disp_vb,
  input  logic [TAG_W-1:0]        disp_qa,
  input  logic [TAG_W-1:0]        disp_qb,
  input  logic [TAG_W-1:0]        disp_dest,
  input  logic                    cdb_valid,
  input  logic [TAG_W-1:0]        cdb_tag,
  input  logic [DATA_W-1:0]       cdb_data,
  output logic                    busy,
  output logic                    ready,
  output logic [Opcode_Width-1:0] op,
  output logic [DATA_W-1:0]       val_a,
  output logic [DATA_W-1:0]       val_b,
  output logic [TAG_W-1:0]        dest
);

  logic                    busy_q, busy_d;
  logic [Opcode_Width-1:0] op_q, op_d;
  logic [TAG_W-1:0]        dest_q, dest_d;
  logic                    a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
  logic [DATA_W-1:0]       a_val_q, a_val_d, b_val_q, b_val_d;
  logic [TAG_W-1:0]        a_tag_q, a_tag_d, b_tag_q, b_tag_d;
  logic                    hit_da, hit_db;

  assign hit_da = cdb_valid && (cdb_tag == disp_qa);
  assign hit_db = cdb_valid && (cdb_tag == disp_qb);

  always_comb begin
    busy_d  = busy_q;
    op_d    = op_q;
    dest_d  = dest_q;
    a_rdy_d = a_rdy_q;
    a_val_d = a_val_q;
    a_tag_d = a_tag_q;
    b_rdy_d = b_rdy_q;
    b_val_d = b_val_q;
    b_tag_d = b_tag_q;
    if (flush) begin
      busy_d = 1'b0;
    end else if (alloc) begin
      busy_d  = 1'b1;
      op_d    = disp_op;
      dest_d  = disp_dest;
      a_tag_d = disp_qa;
      b_tag_d = disp_qb;
      a_rdy_d = disp_qa_valid || hit_da;
      b_rdy_d = disp_qb_valid || hit_db;
      a_val_d = disp_qa_valid ? disp_va : (hit_da ? cdb_data : '0);
      b_val_d = disp_qb_valid ? disp_vb : (hit_db ? cdb_data : '0);
    end else begin
      if (issue) busy_d = 1'b0;
      if (busy_q && !a_rdy_q && cdb_valid && (cdb_tag == a_tag_q)) begin
        a_rdy_d = 1'b1;
        a_val_d = cdb_data;
      end
      if (busy_q && !b_rdy_q && cdb_valid && (cdb_tag == b_tag_q)) begin
        b_rdy_d = 1'b1;
        b_val_d = cdb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      op_q    <= '0;
      dest_q  <= '0;
      a_rdy_q <= 1'b0;
      a_val_q <= '0;
      a_tag_q <= '0;
      b_rdy_q <= 1'b0;
      b_val_q <= '0;
      b_tag_q <= '0;
    end else begin
      busy_q  <= busy_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      a_rdy_q <= a_rdy_d;
      a_val_q <= a_val_d;
      a_tag_q <= a_tag_d;
      b_rdy_q <= b_rdy_d;
      b_val_q <= b_val_d;
      b_tag_q <= b_tag_d;
    end
  end

  assign busy  = busy_q;
  assign ready = busy_q && a_rdy_q && b_rdy_q;
  assign op    = op_q;
  assign val_a = a_val_q;
  assign val_b = b_val_q;
  assign dest  = dest_q;

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: free-slot and issue selection, occupancy count, registered alu_full.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    disp_valid,
  input  logic [Opcode_Width-1:0] disp_op,
  input  logic                    disp_qa_valid,
  input  logic                    disp_qb_valid,
  input  logic [DATA_W-1:0]       disp_va,
  input  logic [DATA_W-1:0]       disp_vb,
  input  logic [TAG_W-1:0]        disp_qa,
  input  logic [TAG_W-1:0]        disp_qb,
  input  logic [TAG_W-1:0]        disp_dest,
  output logic                    alu_full,
  input  logic                    cdb_valid,
  input  logic [TAG_W-1:0]        cdb_tag,
  input  logic [DATA_W-1:0]       cdb_data,
  output logic                    exe_valid,
  input  logic                    exe_ready,
  output logic [Opcode_Width-1:0] exe_op,
  output logic [DATA_W-1:0]       exe_a,
  output logic [DATA_W-1:0]       exe_b,
  output logic [TAG_W-1:0]        exe_dest
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]        busy, ready, alloc, issue;
  logic [Opcode_Width-1:0] e_op   [DEPTH];
  logic [DATA_W-1:0]       e_a    [DEPTH];
  logic [DATA_W-1:0]       e_b    [DEPTH];
  logic [TAG_W-1:0]        e_dest [DEPTH];

  logic            alu_full_q, alu_full_d;
  logic [CntW-1:0] count_q, count_d;
  logic            accept, fire;

  // Count tracks busy entries, so !alu_full_q guarantees a free slot exists.
  assign accept = disp_valid && !alu_full_q && !flush;
  assign fire   = exe_valid && exe_ready && !flush;

  always_comb begin
    alloc = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) alloc = DEPTH'(accept) << i;
    end
  end

  always_comb begin
    exe_valid = 1'b0;
    exe_op    = '0;
    exe_a     = '0;
    exe_b     = '0;
    exe_dest  = '0;
    issue     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        exe_valid = 1'b1;
        exe_op    = e_op[i];
        exe_a     = e_a[i];
        exe_b     = e_b[i];
        exe_dest  = e_dest[i];
        issue     = DEPTH'(fire) << i;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    rs_entry #(
      .DATA_W(DATA_W),
      .TAG_W (TAG_W)
    ) u_entry (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .alloc        (alloc[g]),
      .issue        (issue[g]),
      .disp_op      (disp_op),
      .disp_qa_valid(disp_qa_valid),
      .disp_qb_valid(disp_qb_valid),
      .disp_va      (disp_va),
      .disp_vb      (disp_vb),
      .disp_qa      (disp_qa),
      .disp_qb      (disp_qb),
      .disp_dest    (disp_dest),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_data     (cdb_data),
      .busy         (busy[g]),
      .ready        (ready[g]),
      .op           (e_op[g]),
      .val_a        (e_a[g]),
      .val_b        (e_b[g]),
      .dest         (e_dest[g])
    );
  end

  always_comb begin
    if (flush) count_d = '0;
    else       count_d = count_q + CntW'(accept) - CntW'(fire);
    alu_full_d = (count_d == CntW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      alu_full_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      alu_full_q <= alu_full_d;
    end
  end

  assign alu_full = alu_full_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed vector table plus multi-cycle corner sequences.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    flush;
  logic                    disp_valid;
  logic [Opcode_Width-1:0] disp_op;
  logic                    disp_qa_valid, disp_qb_valid;
  logic [DATA_W-1:0]       disp_va, disp_vb;
  logic [TAG_W-1:0]        disp_qa, disp_qb, disp_dest;
  logic                    alu_full;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic                    exe_valid, exe_ready;
  logic [Opcode_Width-1:0] exe_op;
  logic [DATA_W-1:0]       exe_a, exe_b;
  logic [TAG_W-1:0]        exe_dest;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_rs #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .disp_valid   (disp_valid),
    .disp_op      (disp_op),
    .disp_qa_valid(disp_qa_valid),
    .disp_qb_valid(disp_qb_valid),
    .disp_va      (disp_va),
    .disp_vb      (disp_vb),
    .disp_qa      (disp_qa),
    .disp_qb      (disp_qb),
    .disp_dest    (disp_dest),
    .alu_full     (alu_full),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .exe_valid    (exe_valid),
    .exe_ready    (exe_ready),
    .exe_op       (exe_op),
    .exe_a        (exe_a),
    .exe_b        (exe_b),
    .exe_dest     (exe_dest)
  );

  typedef struct {
    logic [Opcode_Width-1:0] op;
    logic [DATA_W-1:0]       va;
    logic [DATA_W-1:0]       vb;
    logic [TAG_W-1:0]        dest;
    logic [Opcode_Width-1:0] exp_op;
    logic [DATA_W-1:0]       exp_a;
    logic [DATA_W-1:0]       exp_b;
    logic [TAG_W-1:0]        exp_dest;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp_ready(input logic [DATA_W-1:0] va, input logic [DATA_W-1:0] vb,
                            input logic [TAG_W-1:0] dest);
    disp_valid    = 1'b1;
    disp_op       = OpAdd;
    disp_qa_valid = 1'b1;
    disp_qb_valid = 1'b1;
    disp_va       = va;
    disp_vb       = vb;
    disp_dest     = dest;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_op = '0;
    disp_qa_valid = 1'b0; disp_qb_valid = 1'b0; disp_va = '0; disp_vb = '0;
    disp_qa = '0; disp_qb = '0; disp_dest = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; exe_ready = 1'b0;

    vecs[0] = '{OpAdd, 32'd5,        32'd7,        3'd2, OpAdd, 32'd5,        32'd7,        3'd2};
    vecs[1] = '{OpSub, 32'hFFFF_FFFF, 32'd1,        3'd7, OpSub, 32'hFFFF_FFFF, 32'd1,        3'd7};
    vecs[2] = '{OpXor, 32'hA5A5_0000, 32'h0000_5A5A, 3'd0, OpXor, 32'hA5A5_0000, 32'h0000_5A5A, 3'd0};
    vecs[3] = '{OpSlt, 32'd0,        32'h8000_0000, 3'd5, OpSlt, 32'd0,        32'h8000_0000, 3'd5};

    step(); step();
    chk("reset_full", 32'(alu_full), 32'd0);
    chk("reset_exe_valid", 32'(exe_valid), 32'd0);
    chk("reset_exe_a", exe_a, 32'd0);
    chk("reset_exe_dest", 32'(exe_dest), 32'd0);
    rst_n = 1'b1;
    exe_ready = 1'b1;
    step();

    // Direct issue, one vector at a time.
    for (int i = 0; i < 4; i++) begin
      disp_ready(vecs[i].va, vecs[i].vb, vecs[i].dest);
      disp_op = vecs[i].op;
      chk("vec_no_same_cycle", 32'(exe_valid), 32'd0);
      step();
      disp_valid = 1'b0;
      chk("vec_exe_valid", 32'(exe_valid), 32'd1);
      chk("vec_exe_op", 32'(exe_op), 32'(vecs[i].exp_op));
      chk("vec_exe_a", exe_a, vecs[i].exp_a);
      chk("vec_exe_b", exe_b, vecs[i].exp_b);
      chk("vec_exe_dest", 32'(exe_dest), 32'(vecs[i].exp_dest));
      step();
      chk("vec_drained", 32'(exe_valid), 32'd0);
      chk("vec_payload_zero", exe_a, 32'd0);
    end

    // Wakeup: operand A waits on tag 3.
    disp_ready(32'd0, 32'd1, 3'd5);
    disp_qa_valid = 1'b0;
    disp_qa = 3'd3;
    step();
    disp_valid = 1'b0;
    chk("wake_wait0", 32'(exe_valid), 32'd0);
    step();
    chk("wake_wait1", 32'(exe_valid), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'h10;
    #1;
    chk("wake_no_same_cycle", 32'(exe_valid), 32'd0);
    step();
    cdb_valid = 1'b0;
    chk("wake_exe_valid", 32'(exe_valid), 32'd1);
    chk("wake_exe_a", exe_a, 32'h10);
    chk("wake_exe_b", exe_b, 32'd1);
    step();
    chk("wake_drained", 32'(exe_valid), 32'd0);

    // Dispatch bypass: operand B's tag broadcast in the dispatch cycle.
    disp_ready(32'd3, 32'd0, 3'd1);
    disp_qb_valid = 1'b0;
    disp_qb = 3'd4;
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 32'd9;
    step();
    disp_valid = 1'b0; cdb_valid = 1'b0;
    chk("byp_exe_valid", 32'(exe_valid), 32'd1);
    chk("byp_exe_b", exe_b, 32'd9);
    step();
    chk("byp_drained", 32'(exe_valid), 32'd0);

    // Fill with the ALU stalled.
    exe_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp_ready(32'(i + 1), 32'(16 + i), 3'(i));
      step();
      chk("fill_full", 32'(alu_full), (i == 3) ? 32'd1 : 32'd0);
    end
    disp_ready(32'h99, 32'h99, 3'd6);
    step();
    chk("refused_full", 32'(alu_full), 32'd1);
    chk("refused_head", exe_a, 32'd1);
    disp_valid = 1'b0;
    exe_ready = 1'b1;
    step();
    exe_ready = 1'b0;
    chk("drain_full", 32'(alu_full), 32'd0);
    chk("drain_next_a", exe_a, 32'd2);

    // count == DEPTH-1: dispatch plus issue keeps alu_full low.
    disp_ready(32'h55, 32'd0, 3'd6);
    exe_ready = 1'b1;
    step();
    chk("bound_full", 32'(alu_full), 32'd0);
    chk("bound_lowest", exe_a, 32'h55);
    disp_ready(32'h66, 32'd0, 3'd6);
    exe_ready = 1'b0;
    step();
    chk("refill_full", 32'(alu_full), 32'd1);
    chk("refill_hold", exe_a, 32'h55);
    // Full: issue drops alu_full, concurrent dispatch is refused.
    disp_ready(32'h77, 32'd0, 3'd6);
    exe_ready = 1'b1;
    step();
    exe_ready = 1'b0;
    chk("free_full", 32'(alu_full), 32'd0);
    chk("free_next_a", exe_a, 32'h66);
    disp_ready(32'h88, 32'd0, 3'd6);
    step();
    disp_valid = 1'b0;
    chk("count3_full", 32'(alu_full), 32'd1);
    chk("count3_head", exe_a, 32'h88);

    // Flush with a concurrent dispatch.
    disp_ready(32'hAB, 32'd0, 3'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    disp_valid = 1'b0;
    chk("flush_full", 32'(alu_full), 32'd0);
    chk("flush_exe_valid", 32'(exe_valid), 32'd0);
    exe_ready = 1'b1;
    step();
    chk("flush_lost", 32'(exe_valid), 32'd0);
    exe_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp_ready(32'(i + 32), 32'd0, 3'(i));
      step();
      chk("postflush_fill", 32'(alu_full), (i == 3) ? 32'd1 : 32'd0);
    end
    disp_valid = 1'b0;

    // Asynchronous reset mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_full", 32'(alu_full), 32'd0);
    chk("areset_exe_valid", 32'(exe_valid), 32'd0);
    chk("areset_exe_a", exe_a, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("areset_stays_empty", 32'(exe_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Dispatch while full is a protocol error, except where the bench probes refusal.
  int unsigned protocol_hits = 0;
  always @(posedge clk) begin
    if (rst_n && disp_valid && alu_full) protocol_hits++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
